card_dealer: RTL and testbench

- Sits directly downstream of the free-running 12-bit counter.
- Samples the counter value as a pseudo-random seed on each draw request and maps it to one card of a 52-card deck.
- With the no-repeat feature compiled in, it tracks dealt cards so no card repeats until a shuffle.
- Outputs rank, suit and blackjack points to the game FSM over a request/valid handshake.

---
 rtl/card_dealer.sv | 135 +++++++++++++
 tb/tb_card_dealer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/card_dealer.sv
// Card dealer: reduces a sampled counter seed mod 52 and deals one card per request.
// Compile with DEALER_NO_REPEAT_EN to track dealt cards and forbid repeats until shuffle.
module card_dealer #(
   parameter int WIDTH = 12
) (
   input  logic             clk_50M,
   input  logic             i_Reset,
   input  logic [WIDTH-1:0] i_Seed,
   input  logic             i_Req,
   input  logic             i_Shuffle,
   output logic             o_Busy,
   output logic             o_Valid,
   output logic [5:0]       o_Card,
   output logic [3:0]       o_Rank,
   output logic [1:0]       o_Suit,
   output logic [3:0]       o_Points,
   output logic [5:0]       o_Remaining,
   output logic             o_Empty
);

   localparam int DECK_SIZE = 52;
   localparam logic [WIDTH-1:0] DECK_W = WIDTH'(DECK_SIZE);

   typedef enum logic [1:0] {IDLE, REDUCE, PROBE, DEAL} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] r_Idx;
   logic [5:0]       idx6;
   logic [5:0]       base;
   logic [1:0]       suit;
   logic [3:0]       rank;
   logic [3:0]       points;
   logic             take;
   logic             shuffle_eff;
   logic             req_ok;

   assign idx6 = r_Idx[5:0];

`ifdef DEALER_NO_REPEAT_EN
   logic [DECK_SIZE-1:0] used;
   assign take        = !used[idx6];
   assign shuffle_eff = i_Shuffle;
   assign o_Empty     = (o_Remaining == 6'd0);
`else
   logic unused_shuffle;
   assign unused_shuffle = i_Shuffle;
   assign take           = 1'b1;
   assign shuffle_eff    = 1'b0;
   assign o_Remaining    = 6'd52;
   assign o_Empty        = 1'b0;
`endif

   assign req_ok  = i_Req && !o_Empty && !shuffle_eff;
   assign o_Busy  = (state != IDLE);
   assign o_Valid = (state == DEAL);

   // Suit by range compare; rank is the offset inside that suit's 13-card block.
   always_comb begin
      suit = 2'd0;
      base = 6'd0;
      if (idx6 >= 6'd39) begin
         suit = 2'd3;
         base = 6'd39;
      end else if (idx6 >= 6'd26) begin
         suit = 2'd2;
         base = 6'd26;
      end else if (idx6 >= 6'd13) begin
         suit = 2'd1;
         base = 6'd13;
      end
   end

   assign rank   = 4'(idx6 - base) + 4'd1;
   assign points = (rank > 4'd10) ? 4'd10 : rank;

   always_ff @(posedge clk_50M) begin
      if (i_Reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_ok) state_nxt = REDUCE;
         REDUCE:  if (r_Idx < DECK_W) state_nxt = PROBE;
         PROBE:   if (take) state_nxt = DEAL;
         DEAL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_50M) begin
      if (i_Reset) begin
         r_Idx    <= '0;
         o_Card   <= 6'd0;
         o_Rank   <= 4'd0;
         o_Suit   <= 2'd0;
         o_Points <= 4'd0;
`ifdef DEALER_NO_REPEAT_EN
         used        <= '0;
         o_Remaining <= 6'd52;
`endif
      end else begin
         case (state)
            IDLE: begin
`ifdef DEALER_NO_REPEAT_EN
               if (i_Shuffle) begin
                  used        <= '0;
                  o_Remaining <= 6'd52;
               end
`endif
               if (req_ok) r_Idx <= i_Seed;
            end
            // One subtraction per cycle keeps the reduction to a single adder.
            REDUCE: if (r_Idx >= DECK_W) r_Idx <= r_Idx - DECK_W;
            PROBE: begin
               if (take) begin
                  o_Card   <= idx6;
                  o_Rank   <= rank;
                  o_Suit   <= suit;
                  o_Points <= points;
`ifdef DEALER_NO_REPEAT_EN
                  used[idx6]  <= 1'b1;
                  o_Remaining <= o_Remaining - 6'd1;
`endif
               end else begin
                  r_Idx <= (idx6 == 6'd51) ? {WIDTH{1'b0}} : r_Idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer; follows DEALER_NO_REPEAT_EN the same way the RTL does.
module tb_card_dealer;
   localparam int WIDTH = 12;

   logic             clk_50M = 1'b0;
   logic             i_Reset = 1'b1;
   logic [WIDTH-1:0] i_Seed = '0;
   logic             i_Req = 1'b0;
   logic             i_Shuffle = 1'b0;
   logic             o_Busy, o_Valid, o_Empty;
   logic [5:0]       o_Card, o_Remaining;
   logic [3:0]       o_Rank, o_Points;
   logic [1:0]       o_Suit;

   typedef struct {
      int card;
      int rank;
      int suit;
      int pts;
      int rem;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   used_m[52];
   int   rem_m = 52;

   card_dealer #(.WIDTH(WIDTH)) dut (
      .clk_50M    (clk_50M),
      .i_Reset    (i_Reset),
      .i_Seed     (i_Seed),
      .i_Req      (i_Req),
      .i_Shuffle  (i_Shuffle),
      .o_Busy     (o_Busy),
      .o_Valid    (o_Valid),
      .o_Card     (o_Card),
      .o_Rank     (o_Rank),
      .o_Suit     (o_Suit),
      .o_Points   (o_Points),
      .o_Remaining(o_Remaining),
      .o_Empty    (o_Empty)
   );

   always #10 clk_50M = ~clk_50M;

   always @(posedge clk_50M) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   always @(negedge clk_50M) begin
      if (o_Valid) begin
         if (sb.size() == 0) chk("spurious_valid", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("card", int'(o_Card), e.card);
            chk("rank", int'(o_Rank), e.rank);
            chk("suit", int'(o_Suit), e.suit);
            chk("points", int'(o_Points), e.pts);
            chk("remaining", int'(o_Remaining), e.rem);
            chk("empty", int'(o_Empty), (e.rem == 0) ? 1 : 0);
            chk("latency", cyc, e.cyc);
         end
      end
   end

   task automatic model_clear();
      foreach (used_m[i]) used_m[i] = 1'b0;
      rem_m = 52;
   endtask

   task automatic chk_reset_vals();
      chk("rst_busy", int'(o_Busy), 0);
      chk("rst_valid", int'(o_Valid), 0);
      chk("rst_empty", int'(o_Empty), 0);
      chk("rst_card", int'(o_Card), 0);
      chk("rst_rank", int'(o_Rank), 0);
      chk("rst_suit", int'(o_Suit), 0);
      chk("rst_points", int'(o_Points), 0);
      chk("rst_remaining", int'(o_Remaining), 52);
   endtask

   task automatic do_reset();
      @(negedge clk_50M);
      i_Reset = 1'b1;
      i_Req = 1'b0;
      i_Shuffle = 1'b0;
      @(negedge clk_50M);
      i_Reset = 1'b0;
      sb.delete();
      model_clear();
   endtask

   // Drives one request (optionally with shuffle), predicts the outcome and waits for it.
   task automatic draw(input int seed, input bit shuf);
      exp_t e;
      int   idx;
      int   p;
      int   n;
      bit   pushed;
      bit   busy_seen;
      p = 0;
      pushed = 1'b0;
      @(negedge clk_50M);
      i_Seed = WIDTH'(seed);
      i_Req = 1'b1;
      i_Shuffle = shuf;
`ifdef DEALER_NO_REPEAT_EN
      if (shuf) model_clear();
      else if (rem_m != 0) begin
         idx = seed % 52;
         while (used_m[idx]) begin
            idx = (idx == 51) ? 0 : idx + 1;
            p++;
         end
         used_m[idx] = 1'b1;
         rem_m--;
         pushed = 1'b1;
      end
`else
      idx = seed % 52;
      pushed = 1'b1;
`endif
      if (pushed) begin
         e.card = idx;
         e.rank = idx % 13 + 1;
         e.suit = idx / 13;
         e.pts  = (e.rank > 10) ? 10 : e.rank;
         e.rem  = rem_m;
         e.cyc  = cyc + 3 + seed / 52 + p;
         sb.push_back(e);
      end
      @(negedge clk_50M);
      i_Req = 1'b0;
      i_Shuffle = 1'b0;
      if (pushed) begin
         n = 0;
         while (sb.size() != 0 && n < 200) begin
            @(negedge clk_50M);
            n++;
         end
         if (sb.size() != 0) begin
            chk("timeout", sb.size(), 0);
            sb.delete();
         end
      end else begin
         busy_seen = o_Busy;
         repeat (4) begin
            @(negedge clk_50M);
            busy_seen |= o_Busy;
         end
         chk("no_draw_busy", int'(busy_seen), 0);
      end
   endtask

   initial begin
      model_clear();
      repeat (2) @(negedge clk_50M);
      i_Reset = 1'b0;
      chk_reset_vals();

      draw(0, 0);
      draw(100, 0);
      draw(4095, 0);

      do_reset();
      draw(51, 0);
      draw(51, 0);
      draw(7, 0);
      draw(7, 0);

`ifdef DEALER_NO_REPEAT_EN
      while (rem_m > 0) draw($urandom_range(0, 4095), 0);
      chk("deck_empty", int'(o_Empty), 1);
      chk("deck_rem0", int'(o_Remaining), 0);
      draw(5, 0);
`endif
      draw(9, 1);
      chk("rem_after_shuffle", int'(o_Remaining), rem_m);

      // Reset while the seed is still being reduced: the draw must vanish.
      @(negedge clk_50M);
      i_Seed = 12'd4095;
      i_Req = 1'b1;
      @(negedge clk_50M);
      i_Req = 1'b0;
      repeat (3) @(negedge clk_50M);
      chk("busy_mid_reduce", int'(o_Busy), 1);
      do_reset();
      chk_reset_vals();
      repeat (100) @(negedge clk_50M);
      chk("idle_after_reset", int'(o_Busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
